// File: rtl/rf_wb_arbiter.sv
// rf_wb_arbiter
//   Write-back controller for the 2R/1W register file. NUM_REQ producers share
//   the single write port through a round-robin arbiter with valid/ready
//   handshakes. A per-register busy scoreboard lets the issue stage detect
//   RAW hazards. Register 0 is hardwired zero: writes to it are accepted but
//   never assert rf_wen.
//
// Ports
//   clk, rst              clock (rising edge), asynchronous active-high reset
//   req_valid/req_ready   per-requester handshake; ready is one-hot or zero
//   req_addr/req_data     flattened per-requester index/data, slice i at
//                         [i*W +: W]
//   rf_wen/waddr/wdata    registered write port into the register file
//   rsv_en/rsv_addr       issue-stage reservation of a destination register
//   busy                  registered scoreboard, bit r set while r is pending

module rf_wb_arbiter #(
    parameter int ADDR_WIDTH = 5,
    parameter int DATA_WIDTH = 32,
    parameter int NUM_REQ    = 3
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [NUM_REQ-1:0]              req_valid,
    output logic [NUM_REQ-1:0]              req_ready,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0]   req_addr,
    input  logic [NUM_REQ*DATA_WIDTH-1:0]   req_data,
    output logic                            rf_wen,
    output logic [ADDR_WIDTH-1:0]           rf_waddr,
    output logic [DATA_WIDTH-1:0]           rf_wdata,
    input  logic                            rsv_en,
    input  logic [ADDR_WIDTH-1:0]           rsv_addr,
    output logic [(2**ADDR_WIDTH)-1:0]      busy
);

    localparam int PTR_W = $clog2(NUM_REQ);
    localparam int NREG  = 2**ADDR_WIDTH;

    logic [PTR_W-1:0]      r_ptr;
    logic                  r_wen;
    logic [ADDR_WIDTH-1:0] r_waddr;
    logic [DATA_WIDTH-1:0] r_wdata;
    logic [NREG-1:0]       r_busy;

    logic [NUM_REQ-1:0]    w_grant;
    logic                  w_xfer;
    logic [PTR_W-1:0]      w_ptr_nxt;
    logic [ADDR_WIDTH-1:0] w_addr;
    logic [DATA_WIDTH-1:0] w_data;
    logic [NREG-1:0]       w_busy_nxt;

    // Port examined at search step k, starting from the round-robin pointer.
    function automatic int rr_idx(input int base, input int k);
        return (base + k) % NUM_REQ;
    endfunction

    // First valid port at or after r_ptr (wrapping) wins; the winner's
    // addr/data are muxed out here so the write stage is a plain register.
    always_comb begin
        w_grant   = '0;
        w_xfer    = 1'b0;
        w_ptr_nxt = r_ptr;
        w_addr    = '0;
        w_data    = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (!w_xfer && req_valid[rr_idx(int'(r_ptr), k)]) begin
                w_xfer = 1'b1;
                w_grant[rr_idx(int'(r_ptr), k)] = 1'b1;
                w_ptr_nxt = PTR_W'((rr_idx(int'(r_ptr), k) + 1) % NUM_REQ);
                w_addr = req_addr[rr_idx(int'(r_ptr), k)*ADDR_WIDTH +: ADDR_WIDTH];
                w_data = req_data[rr_idx(int'(r_ptr), k)*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    // Ready must read 0 during reset even though it is combinational.
    assign req_ready = rst ? '0 : w_grant;

    // Clear first, then set, so a same-edge reservation of the register being
    // written back leaves it busy (a newer producer is outstanding).
    always_comb begin
        w_busy_nxt = r_busy;
        if (r_wen)
            w_busy_nxt[r_waddr] = 1'b0;
        if (rsv_en && (rsv_addr != '0))
            w_busy_nxt[rsv_addr] = 1'b1;
        w_busy_nxt[0] = 1'b0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ptr   <= '0;
            r_wen   <= 1'b0;
            r_waddr <= '0;
            r_wdata <= '0;
            r_busy  <= '0;
        end else begin
            r_busy <= w_busy_nxt;
            if (w_xfer) begin
                r_ptr   <= w_ptr_nxt;
                r_waddr <= w_addr;
                r_wdata <= w_data;
                r_wen   <= (w_addr != '0);
            end else begin
                r_wen   <= 1'b0;
            end
        end
    end

    assign rf_wen   = r_wen;
    assign rf_waddr = r_waddr;
    assign rf_wdata = r_wdata;
    assign busy     = r_busy;

endmodule

// File: tb/tb_rf_wb_arbiter.sv
module tb_rf_wb_arbiter;

    localparam int AW   = 5;
    localparam int DW   = 32;
    localparam int NR   = 3;
    localparam int NREG = 32;

    logic              clk = 1'b0;
    logic              rst;
    logic [NR-1:0]     req_valid;
    logic [NR-1:0]     req_ready;
    logic [NR*AW-1:0]  req_addr;
    logic [NR*DW-1:0]  req_data;
    logic              rf_wen;
    logic [AW-1:0]     rf_waddr;
    logic [DW-1:0]     rf_wdata;
    logic              rsv_en;
    logic [AW-1:0]     rsv_addr;
    logic [NREG-1:0]   busy;

    rf_wb_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_REQ(NR)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_addr(req_addr), .req_data(req_data),
        .rf_wen(rf_wen), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
        .rsv_en(rsv_en), .rsv_addr(rsv_addr), .busy(busy)
    );

    always #5 clk = ~clk;

    int n_total = 0;
    int n_pass  = 0;

    // Producer-side view of requests
    bit          v_valid [NR];
    logic [AW-1:0] v_addr [NR];
    logic [DW-1:0] v_data [NR];

    // Reference model state
    int            m_ptr;
    logic          m_wen;
    logic [AW-1:0] m_waddr;
    logic [DW-1:0] m_wdata;
    logic [NREG-1:0] m_busy;
    int            gcount [NR];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic model_reset();
        m_ptr = 0; m_wen = 0; m_waddr = '0; m_wdata = '0; m_busy = '0;
    endtask

    task automatic apply();
        for (int i = 0; i < NR; i++) begin
            req_valid[i] = v_valid[i];
            req_addr[i*AW +: AW] = v_addr[i];
            req_data[i*DW +: DW] = v_data[i];
        end
    endtask

    function automatic int exp_grant();
        for (int k = 0; k < NR; k++)
            if (v_valid[(m_ptr + k) % NR]) return (m_ptr + k) % NR;
        return -1;
    endfunction

    // One clock: entered and left at posedge+1. Checks ready before the edge
    // and the registered outputs after it against the model.
    task automatic cycle(output int g);
        logic [NREG-1:0] nb;
        logic [NR-1:0] er;
        apply();
        #3;
        g = exp_grant();
        er = '0;
        if (g >= 0) er[g] = 1'b1;
        chk("req_ready", 64'(req_ready), 64'(er));
        nb = m_busy;
        if (m_wen) nb[m_waddr] = 1'b0;
        if (rsv_en && rsv_addr != 0) nb[rsv_addr] = 1'b1;
        if (g >= 0) begin
            m_wen = (v_addr[g] != 0);
            m_waddr = v_addr[g];
            m_wdata = v_data[g];
            m_ptr = (g + 1) % NR;
            gcount[g]++;
        end else begin
            m_wen = 1'b0;
        end
        m_busy = nb;
        @(posedge clk);
        #1;
        chk("rf_wen", 64'(rf_wen), 64'(m_wen));
        chk("rf_waddr", 64'(rf_waddr), 64'(m_waddr));
        chk("rf_wdata", 64'(rf_wdata), 64'(m_wdata));
        chk("busy", 64'(busy), 64'(m_busy));
    endtask

    task automatic idle_all();
        for (int i = 0; i < NR; i++) v_valid[i] = 0;
        rsv_en = 0;
    endtask

    initial begin
        int g;
        rst = 1'b1;
        rsv_en = 0; rsv_addr = '0;
        for (int i = 0; i < NR; i++) begin
            v_valid[i] = 0; v_addr[i] = '0; v_data[i] = '0; gcount[i] = 0;
        end
        apply();
        model_reset();

        // Reset state over 5 cycles
        for (int c = 0; c < 5; c++) begin
            @(posedge clk); #1;
            chk("rst_wen", 64'(rf_wen), 0);
            chk("rst_waddr", 64'(rf_waddr), 0);
            chk("rst_wdata", 64'(rf_wdata), 0);
            chk("rst_busy", 64'(busy), 0);
            chk("rst_ready", 64'(req_ready), 0);
        end
        req_valid = '1;
        #1 chk("rst_ready_valid", 64'(req_ready), 0);
        req_valid = '0;
        @(posedge clk); #1;
        rst = 1'b0;

        // Single write from port 1
        v_valid[1] = 1; v_addr[1] = 5'd5; v_data[1] = 32'hDEADBEEF;
        cycle(g);
        chk("single_grant", 64'(g), 1);
        chk("single_wen", 64'(rf_wen), 1);
        chk("single_waddr", 64'(rf_waddr), 5);
        chk("single_wdata", 64'(rf_wdata), 64'hDEADBEEF);
        idle_all();
        cycle(g);
        chk("single_wen_off", 64'(rf_wen), 0);
        chk("single_wdata_hold", 64'(rf_wdata), 64'hDEADBEEF);

        // Write to register 0 from port 2: accepted, no rf_wen
        v_valid[2] = 1; v_addr[2] = '0; v_data[2] = 32'h1234;
        cycle(g);
        chk("r0_grant", 64'(g), 2);
        chk("r0_wen", 64'(rf_wen), 0);
        chk("r0_busy", 64'(busy), 0);
        idle_all();

        // Fairness: all ports valid, pointer is back at 0
        for (int i = 0; i < NR; i++) begin
            gcount[i] = 0; v_addr[i] = AW'(i + 1); v_data[i] = 32'hA000 + i;
        end
        for (int c = 0; c < 6; c++) begin
            for (int i = 0; i < NR; i++) v_valid[i] = 1;
            cycle(g);
            chk("fair_grant", 64'(g), 64'(c % 3));
            chk("fair_wen", 64'(rf_wen), 1);
        end
        for (int i = 0; i < NR; i++) chk("fair_count", 64'(gcount[i]), 2);
        idle_all();
        cycle(g);

        // Scoreboard: reserve 7, write back 7, busy clears one cycle later
        rsv_en = 1; rsv_addr = 5'd7;
        cycle(g);
        rsv_en = 0;
        chk("sb_set", 64'(busy[7]), 1);
        cycle(g);
        cycle(g);
        v_valid[0] = 1; v_addr[0] = 5'd7; v_data[0] = 32'h77;
        cycle(g);
        v_valid[0] = 0;
        chk("sb_wen7", 64'(rf_wen), 1);
        chk("sb_still_busy", 64'(busy[7]), 1);
        cycle(g);
        chk("sb_clear", 64'(busy[7]), 0);

        // Same-edge set and clear: set wins
        rsv_en = 1; rsv_addr = 5'd7;
        cycle(g);
        rsv_en = 0;
        v_valid[0] = 1; v_addr[0] = 5'd7; v_data[0] = 32'h78;
        cycle(g);
        v_valid[0] = 0;
        rsv_en = 1; rsv_addr = 5'd7;
        cycle(g);
        rsv_en = 0;
        chk("sb_set_wins", 64'(busy[7]), 1);

        // Async reset while rf_wen=1 and busy=0x80
        v_valid[1] = 1; v_addr[1] = 5'd9; v_data[1] = 32'h99;
        cycle(g);
        chk("ar_pre_wen", 64'(rf_wen), 1);
        chk("ar_pre_busy", 64'(busy), 64'h80);
        for (int i = 0; i < NR; i++) v_valid[i] = 1;
        apply();
        #1 rst = 1'b1;
        #1;
        chk("ar_wen", 64'(rf_wen), 0);
        chk("ar_waddr", 64'(rf_waddr), 0);
        chk("ar_wdata", 64'(rf_wdata), 0);
        chk("ar_busy", 64'(busy), 0);
        chk("ar_ready", 64'(req_ready), 0);
        model_reset();
        @(posedge clk); #1;
        rst = 1'b0;
        cycle(g);
        chk("ar_first_grant", 64'(g), 0);
        idle_all();
        cycle(g);

        // Randomized traffic against the model
        for (int c = 0; c < 400; c++) begin
            for (int i = 0; i < NR; i++) begin
                if (!v_valid[i]) begin
                    if ($urandom_range(0, 1) == 1) begin
                        v_valid[i] = 1;
                        v_addr[i] = ($urandom_range(0, 7) == 0) ? '0 : AW'($urandom_range(0, NREG - 1));
                        v_data[i] = $urandom;
                    end
                end else if ($urandom_range(0, 15) == 0) begin
                    v_valid[i] = 0;
                end
            end
            rsv_en = ($urandom_range(0, 2) == 0);
            rsv_addr = AW'($urandom_range(0, NREG - 1));
            cycle(g);
            if (g >= 0) v_valid[g] = 0;
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
